seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div_if.sv | 27 ++
 rtl/seq_div.sv | 176 +++++++++++++++++
 tb/tb_seq_div.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// seq_div_if: handshake and result bundle for the sequential divider.
//   start  - request a divide (master -> slave)
//   A, B   - dividend / divisor, 8 bits (master -> slave)
//   busy   - division in progress (slave -> master)
//   done   - one-cycle pulse, Q/R/dz valid (slave -> master)
//   Q, R   - quotient / remainder, 8 bits (slave -> master)
//   dz     - divide-by-zero flag of the last completed operation (slave -> master)
interface seq_div_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Q;
  logic [7:0] R;
  logic       dz;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, dz
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, dz
  );
endinterface

// File: rtl/seq_div.sv
// seq_div: 8-bit restoring shift-subtract divider, one quotient bit per cycle.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_div_if.slave: start/A/B in, busy/done/Q/R/dz out
// A start accepted in IDLE latches A/B; eight RUN cycles later Q/R/dz update and
// done pulses for one cycle. A zero divisor completes on the accepting edge with
// Q=8'hFF, R=A, dz=1.
// Optional feature: define SEQ_DIV_SIGNED_EN for two's complement operands; the
// magnitudes are divided and signs applied afterwards (Q toward zero, R follows A).
module seq_div (
  input logic   clk,
  input logic   rst_n,
  seq_div_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [2:0] cnt_q, cnt_d;
  // Shifts dividend bits out of the top while quotient bits enter at the bottom.
  logic [7:0] quo_q, quo_d;
  logic [8:0] rem_q, rem_d;
  logic [7:0] dvs_q, dvs_d;

  logic [7:0] q_out_q, q_out_d;
  logic [7:0] r_out_q, r_out_d;
  logic       dz_q, dz_d;
  logic       done_q, done_d;

`ifdef SEQ_DIV_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  function automatic logic [7:0] magnitude(input logic [7:0] v);
    // 8'h80 maps to 8'h80, i.e. 128 when read unsigned.
    return v[7] ? (~v + 8'd1) : v;
  endfunction
`endif

  logic       accept;
  logic       div_zero;
  logic       last_iter;
  logic [8:0] rem_shift;
  logic       fits;
  logic [8:0] rem_next;
  logic [7:0] quo_next;
  logic [7:0] q_res;
  logic [7:0] r_res;

  // Control strobes shared by next-state and datapath logic.
  always_comb begin
    accept    = (state_q == StIdle) && bus.start && (bus.B != 8'd0);
    div_zero  = (state_q == StIdle) && bus.start && (bus.B == 8'd0);
    last_iter = (state_q == StRun) && (cnt_q == 3'd7);
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRun;
      StRun:  if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = done_q;
    bus.Q    = q_out_q;
    bus.R    = r_out_q;
    bus.dz   = dz_q;
  end

  // One restoring iteration.
  always_comb begin
    rem_shift = {rem_q[7:0], quo_q[7]};
    fits      = (rem_shift >= {1'b0, dvs_q});
    rem_next  = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    quo_next  = {quo_q[6:0], fits};
`ifdef SEQ_DIV_SIGNED_EN
    q_res     = q_neg_q ? (~quo_next + 8'd1) : quo_next;
    r_res     = r_neg_q ? (~rem_next[7:0] + 8'd1) : rem_next[7:0];
`else
    q_res     = quo_next;
    r_res     = rem_next[7:0];
`endif
  end

  // Datapath next state.
  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`endif
    if (accept) begin
      cnt_d = 3'd0;
      rem_d = 9'd0;
`ifdef SEQ_DIV_SIGNED_EN
      quo_d   = magnitude(bus.A);
      dvs_d   = magnitude(bus.B);
      q_neg_d = bus.A[7] ^ bus.B[7];
      r_neg_d = bus.A[7];
`else
      quo_d = bus.A;
      dvs_d = bus.B;
`endif
    end else if (div_zero) begin
      q_out_d = 8'hFF;
      r_out_d = bus.A;
      dz_d    = 1'b1;
      done_d  = 1'b1;
    end else if (state_q == StRun) begin
      quo_d = quo_next;
      rem_d = rem_next;
      cnt_d = cnt_q + 3'd1;
      if (last_iter) begin
        q_out_d = q_res;
        r_out_d = r_res;
        dz_d    = 1'b0;
        done_d  = 1'b1;
        cnt_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      quo_q   <= 8'd0;
      rem_q   <= 9'd0;
      dvs_q   <= 8'd0;
      q_out_q <= 8'd0;
      r_out_q <= 8'd0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_div_if bus ();

  seq_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz);
    int ia, ib, iq, ir;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      ia = int'($signed(a));
      ib = int'($signed(b));
`else
      ia = int'(a);
      ib = int'(b);
`endif
      iq = ia / ib;
      ir = ia % ib;
      q  = iq[7:0];
      r  = ir[7:0];
      dz = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from an idle point (#1 after an edge) and check timing/results.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int bad;
    bus.start = 1'b1; bus.A = a; bus.B = b;
    tick();
    bus.start = 1'b0; bus.A = ~a; bus.B = ~b;
    if (b == 8'd0) begin
      chk({tag, " dz_busy"}, int'(bus.busy), 0);
      chk({tag, " dz_done"}, int'(bus.done), 1);
    end else begin
      bad = 0;
      for (int i = 1; i < 8; i++) begin
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        tick();
      end
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      chk({tag, " busy_window_errs"}, bad, 0);
      tick();
      chk({tag, " done_e8"}, int'(bus.done), 1);
      chk({tag, " busy_e8"}, int'(bus.busy), 0);
    end
    chk({tag, " Q"}, int'(bus.Q), int'(eq));
    chk({tag, " R"}, int'(bus.R), int'(er));
    chk({tag, " dz"}, int'(bus.dz), int'(edz));
    tick();
    chk({tag, " done_drop"}, int'(bus.done), 0);
    chk({tag, " Q_hold"}, int'(bus.Q), int'(eq));
  endtask

  initial begin
    vec_t       vecs[$];
    logic [7:0] eq, er, a, b;
    logic       edz;
    int         bad;

    checks = 0;
    failures = 0;
    bus.start = 1'b0; bus.A = 8'd0; bus.B = 8'd0;
    rst_n = 1'b0;
    #1;
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst Q", int'(bus.Q), 0);
    chk("rst R", int'(bus.R), 0);
    chk("rst dz", int'(bus.dz), 0);
    #12 rst_n = 1'b1;
    tick();

`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{8'hF9, 8'd2,   8'hFD, 8'hFF, 1'b0});
    vecs.push_back('{8'h80, 8'hFF,  8'h80, 8'h00, 1'b0});
    vecs.push_back('{8'd100, 8'd7,  8'd14, 8'd2,  1'b0});
    vecs.push_back('{8'd7,  8'hFE,  8'hFD, 8'd1,  1'b0});
    vecs.push_back('{8'hF9, 8'd0,   8'hFF, 8'hF9, 1'b1});
    vecs.push_back('{8'h7F, 8'd3,   8'd42, 8'd1,  1'b0});
`else
    vecs.push_back('{8'd100, 8'd7,  8'd14,  8'd2,   1'b0});
    vecs.push_back('{8'd3,   8'd2,  8'd1,   8'd1,   1'b0});
    vecs.push_back('{8'd7,   8'd9,  8'd0,   8'd7,   1'b0});
    vecs.push_back('{8'd5,   8'd0,  8'hFF,  8'd5,   1'b1});
    vecs.push_back('{8'd255, 8'd1,  8'd255, 8'd0,   1'b0});
    vecs.push_back('{8'd0,   8'd5,  8'd0,   8'd0,   1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,  8'd0,   1'b0});
    vecs.push_back('{8'd1,   8'd255, 8'd0,  8'd1,   1'b0});
    vecs.push_back('{8'd200, 8'd3,  8'd66,  8'd2,   1'b0});
`endif
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // start held high through a run: ignored until E9, then accepted back-to-back.
    bus.start = 1'b1; bus.A = 8'd200; bus.B = 8'd3;
    tick();
    bus.A = 8'd9; bus.B = 8'd3;
    for (int i = 1; i < 8; i++) tick();
    tick();
    ref_div(8'd200, 8'd3, eq, er, edz);
    chk("b2b done_e8", int'(bus.done), 1);
    chk("b2b Q_e8", int'(bus.Q), int'(eq));
    chk("b2b R_e8", int'(bus.R), int'(er));
    tick();
    bus.start = 1'b0;
    chk("b2b done_e9", int'(bus.done), 0);
    chk("b2b busy_e9", int'(bus.busy), 1);
    for (int i = 10; i < 17; i++) tick();
    chk("b2b done_e16", int'(bus.done), 0);
    tick();
    ref_div(8'd9, 8'd3, eq, er, edz);
    chk("b2b done_e17", int'(bus.done), 1);
    chk("b2b Q_e17", int'(bus.Q), int'(eq));
    chk("b2b R_e17", int'(bus.R), int'(er));
    tick();

    // Reset in the middle of a run.
    bus.start = 1'b1; bus.A = 8'd100; bus.B = 8'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst done", int'(bus.done), 0);
    chk("midrst Q", int'(bus.Q), 0);
    chk("midrst R", int'(bus.R), 0);
    chk("midrst dz", int'(bus.dz), 0);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("midrst no_done", bad, 0);
    ref_div(8'd100, 8'd7, eq, er, edz);
    run_op("post_rst", 8'd100, 8'd7, eq, er, edz);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      ref_div(a, b, eq, er, edz);
      run_op($sformatf("rnd%0d a=%0d b=%0d", n, a, b), a, b, eq, er, edz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
